// File: rtl/vram_console_writer_pkg.sv
// Shared definitions for the text console writer: FSM states, control
// codes, default geometry and the printable-byte classifier.
// CONSOLE_SCROLL_EN adds the SCR_RD/SCR_WR states used for scrolling.
package console_pkg;

  localparam int COLS_DEFAULT = 60;  // 480 px / 8 px glyph width
  localparam int ROWS_DEFAULT = 17;  // 272 px / 16 px glyph height

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [2:0] {
    CLR_ALL = 3'd0,
    IDLE    = 3'd1,
    PUT     = 3'd2,
`ifdef CONSOLE_SCROLL_EN
    SCR_RD  = 3'd3,
    SCR_WR  = 3'd4,
`endif
    CLR_ROW = 3'd5
  } console_state_t;

  // Glyph bytes: 0x20..0x7E and 0x80..0xFF. 0x7F (DEL) is swallowed.
  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c != 8'h7F);
  endfunction

endpackage

// File: rtl/vram_console_writer_if.sv
// Byte-stream input, VRAM write/read port and cursor status of the console
// writer. master = the writer itself, slave = the byte source / VRAM side.
interface vram_console_writer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [9:0] v_ada;
  logic [7:0] v_dina;
  logic       v_wea;
  logic [7:0] v_douta;
  logic [5:0] cur_col;
  logic [4:0] cur_row;
  logic       busy;

  modport master (
    input  in_valid, in_data, v_douta,
    output in_ready, v_ada, v_dina, v_wea, cur_col, cur_row, busy
  );

  modport slave (
    output in_valid, in_data, v_douta,
    input  in_ready, v_ada, v_dina, v_wea, cur_col, cur_row, busy
  );
endinterface

// File: rtl/vram_console_writer.sv
// Character-stream writer for the text VRAM. Accepts bytes on a valid/ready
// handshake, keeps a cursor, writes glyph codes and handles CR, LF, BS, FF,
// line wrap and end-of-screen. With CONSOLE_SCROLL_EN defined the screen
// scrolls up one row; otherwise the cursor wraps to row 0 and clears it.
module vram_console_writer
  import console_pkg::*;
#(
  parameter int COLS = COLS_DEFAULT,
  parameter int ROWS = ROWS_DEFAULT
) (
  input logic PixelClk,
  input logic nRST,
  vram_console_writer_if.master bus
);

  localparam logic [10:0] CELLS       = 11'(COLS * ROWS);
  localparam logic [10:0] CNT_COL_END = 11'(COLS - 1);
  localparam logic [9:0]  COLS_A      = 10'(COLS);
  localparam logic [5:0]  COL_LAST    = 6'(COLS - 1);
  localparam logic [4:0]  ROW_LAST    = 5'(ROWS - 1);

  // Entry point of the end-of-screen sequence and the first VRAM access it
  // presents: a read of row 1 for a scroll, a blank write of row 0 otherwise.
`ifdef CONSOLE_SCROLL_EN
  localparam logic [10:0] SCR_LAST      = 11'((ROWS - 1) * COLS - 1);
  localparam logic [9:0]  ROW_LAST_BASE = 10'((ROWS - 1) * COLS);
  localparam console_state_t WRAP_STATE = SCR_RD;
  localparam logic [9:0]  WRAP_ADA      = COLS_A;
  localparam logic        WRAP_WEA      = 1'b0;
`else
  localparam console_state_t WRAP_STATE = CLR_ROW;
  localparam logic [9:0]  WRAP_ADA      = 10'd0;
  localparam logic        WRAP_WEA      = 1'b1;
`endif

  console_state_t state_reg;
  logic           in_ready_reg;
  logic           busy_reg;
  logic           v_wea_reg;
  logic [9:0]     v_ada_reg;
  logic [7:0]     v_dina_reg;
  logic [5:0]     cur_col_reg;
  logic [4:0]     cur_row_reg;
  logic [9:0]     cur_addr_reg;  // cur_row*COLS + cur_col, tracked incrementally
  logic [10:0]    cnt_reg;       // cell / scroll-step / column counter
  logic           wrap_reg;      // a glyph write wrapped off the last row

  // Main FSM: every branch loads the outputs for the state it enters next.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state_reg    <= CLR_ALL;
      in_ready_reg <= 1'b0;
      busy_reg     <= 1'b1;
      v_wea_reg    <= 1'b0;
      v_ada_reg    <= 10'd0;
      v_dina_reg   <= CH_SPACE;
      cur_col_reg  <= 6'd0;
      cur_row_reg  <= 5'd0;
      cur_addr_reg <= 10'd0;
      cnt_reg      <= 11'd0;
      wrap_reg     <= 1'b0;
    end else begin
      case (state_reg)
        CLR_ALL: begin
          if (cnt_reg == CELLS) begin
            state_reg    <= IDLE;
            v_wea_reg    <= 1'b0;
            in_ready_reg <= 1'b1;
            busy_reg     <= 1'b0;
          end else begin
            v_wea_reg  <= 1'b1;
            v_ada_reg  <= cnt_reg[9:0];
            v_dina_reg <= CH_SPACE;
            cnt_reg    <= cnt_reg + 11'd1;
          end
        end

        IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= PUT;
            v_wea_reg    <= 1'b0;
            if (is_printable(bus.in_data)) begin
              v_wea_reg  <= 1'b1;
              v_ada_reg  <= cur_addr_reg;
              v_dina_reg <= bus.in_data;
              if (cur_col_reg != COL_LAST) begin
                cur_col_reg  <= cur_col_reg + 6'd1;
                cur_addr_reg <= cur_addr_reg + 10'd1;
              end else begin
                cur_col_reg <= 6'd0;
                if (cur_row_reg != ROW_LAST) begin
                  cur_row_reg  <= cur_row_reg + 5'd1;
                  cur_addr_reg <= cur_addr_reg + 10'd1;
                end else begin
                  wrap_reg <= 1'b1;
`ifdef CONSOLE_SCROLL_EN
                  cur_addr_reg <= ROW_LAST_BASE;
`else
                  cur_row_reg  <= 5'd0;
                  cur_addr_reg <= 10'd0;
`endif
                end
              end
            end else begin
              case (bus.in_data)
                CH_CR: begin
                  cur_col_reg  <= 6'd0;
                  cur_addr_reg <= cur_addr_reg - {4'd0, cur_col_reg};
                end
                CH_LF: begin
                  if (cur_row_reg != ROW_LAST) begin
                    cur_row_reg  <= cur_row_reg + 5'd1;
                    cur_addr_reg <= cur_addr_reg + COLS_A;
                  end else begin
`ifndef CONSOLE_SCROLL_EN
                    cur_row_reg  <= 5'd0;
                    cur_addr_reg <= {4'd0, cur_col_reg};
`endif
                    state_reg  <= WRAP_STATE;
                    v_ada_reg  <= WRAP_ADA;
                    v_wea_reg  <= WRAP_WEA;
                    v_dina_reg <= CH_SPACE;
                    cnt_reg    <= 11'd0;
                  end
                end
                CH_BS: begin
                  if (cur_col_reg != 6'd0) begin
                    cur_col_reg  <= cur_col_reg - 6'd1;
                    cur_addr_reg <= cur_addr_reg - 10'd1;
                    v_wea_reg    <= 1'b1;
                    v_ada_reg    <= cur_addr_reg - 10'd1;
                    v_dina_reg   <= CH_SPACE;
                  end
                end
                CH_FF: begin
                  state_reg    <= CLR_ALL;
                  cnt_reg      <= 11'd0;
                  cur_col_reg  <= 6'd0;
                  cur_row_reg  <= 5'd0;
                  cur_addr_reg <= 10'd0;
                end
                default: ;
              endcase
            end
          end
        end

        PUT: begin
          if (wrap_reg) begin
            wrap_reg   <= 1'b0;
            state_reg  <= WRAP_STATE;
            v_ada_reg  <= WRAP_ADA;
            v_wea_reg  <= WRAP_WEA;
            v_dina_reg <= CH_SPACE;
            cnt_reg    <= 11'd0;
          end else begin
            state_reg    <= IDLE;
            v_wea_reg    <= 1'b0;
            in_ready_reg <= 1'b1;
            busy_reg     <= 1'b0;
          end
        end

`ifdef CONSOLE_SCROLL_EN
        SCR_RD: begin
          state_reg <= SCR_WR;
          v_ada_reg <= cnt_reg[9:0];
          v_wea_reg <= 1'b1;
        end

        SCR_WR: begin
          if (cnt_reg == SCR_LAST) begin
            state_reg  <= CLR_ROW;
            v_ada_reg  <= ROW_LAST_BASE;
            v_dina_reg <= CH_SPACE;
            v_wea_reg  <= 1'b1;
            cnt_reg    <= 11'd0;
          end else begin
            state_reg <= SCR_RD;
            v_ada_reg <= cnt_reg[9:0] + 10'd1 + COLS_A;
            v_wea_reg <= 1'b0;
            cnt_reg   <= cnt_reg + 11'd1;
          end
        end
`endif

        CLR_ROW: begin
          if (cnt_reg == CNT_COL_END) begin
            state_reg    <= IDLE;
            v_wea_reg    <= 1'b0;
            in_ready_reg <= 1'b1;
            busy_reg     <= 1'b0;
          end else begin
            v_ada_reg <= v_ada_reg + 10'd1;
            cnt_reg   <= cnt_reg + 11'd1;
          end
        end

        default: begin
          state_reg <= CLR_ALL;
          cnt_reg   <= 11'd0;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_reg;
  assign bus.busy     = busy_reg;
  assign bus.v_wea    = v_wea_reg;
  assign bus.v_ada    = v_ada_reg;
  assign bus.cur_col  = cur_col_reg;
  assign bus.cur_row  = cur_row_reg;

`ifdef CONSOLE_SCROLL_EN
  // The BSRAM read issued in SCR_RD is valid during SCR_WR; it is forwarded
  // straight to the write port so each moved cell costs two cycles.
  assign bus.v_dina = (state_reg == SCR_WR) ? bus.v_douta : v_dina_reg;
`else
  assign bus.v_dina = v_dina_reg;
  logic unused_douta;
  assign unused_douta = ^bus.v_douta;
`endif

endmodule

// File: doc/vram_console_writer.md
# vram_console_writer

Character-stream writer for the text VRAM scanned by `lcd`. It accepts ASCII bytes over a valid/ready handshake and maintains a cursor. It writes glyph codes into the VRAM write/read port (the side opposite the `v_adb`/`v_dout` scan port) and handles CR, LF, BS, FF, line wrap and scrolling. It sits between the CPU/UART byte source and the dual-port BSRAM, in the `PixelClk` domain.

## Interface
- `COLS`, 60: text columns (480 px / 8).
- `ROWS`, 17: text rows (272 px / 16); `COLS*ROWS` must be ≤ 1024.
- `PixelClk  in  1`: single clock for the block.
- `nRST  in  1`: reset, asynchronous, active-low.
- `in_valid  in  1`: `in_data` is valid.
- `in_data  in  8`: character byte.
- `in_ready  out  1`: byte accepted on a cycle where `in_valid && in_ready`.
- `v_ada  out  10`: VRAM port address.
- `v_dina  out  8`: VRAM write data.
- `v_wea  out  1`: VRAM write enable.
- `v_douta  in  8`: VRAM read data, valid 1 cycle after its address.
- `cur_col  out  6`: cursor column.
- `cur_row  out  5`: cursor row.
- `busy  out  1`: high in any state other than IDLE.

## Operation
- States: CLR_ALL, IDLE, PUT, SCR_RD, SCR_WR, CLR_ROW.
- Cursor linear address `cur_addr` = `cur_row*COLS + cur_col`.
  - Kept as a register and updated incrementally; no multiplier.
- Byte handling in IDLE:
  - 0x20–0x7E and 0x80–0xFF: PUT writes `in_data` at `cur_addr`, then advances the cursor.
  - 0x0D (CR): `cur_col`=0.
  - 0x0A (LF): newline.
  - 0x08 (BS): if `cur_col`>0, decrement the column and write 0x20 at the new address. At `cur_col`=0 it is a no-op.
  - 0x0C (FF): CLR_ALL, then cursor 0,0.
  - Other 0x00–0x1F: consumed and ignored.
- Advance:
  - If `cur_col` < COLS-1, `cur_col`+1.
  - If `cur_col` = COLS-1, `cur_col`=0 and newline.
- Newline:
  - If `cur_row` < ROWS-1, `cur_row`+1.
  - Otherwise scroll (see Configuration); the cursor stays on row ROWS-1.
- Scroll:
  - For d = 0 .. (ROWS-1)*COLS-1, SCR_RD drives `v_ada`=d+COLS with `v_wea`=0.
  - The next cycle, SCR_WR drives `v_ada`=d, `v_dina`=`v_douta`, `v_wea`=1.
  - Then CLR_ROW writes 0x20 to the COLS cells of the last row.
- CLR_ALL writes 0x20 to addresses 0..COLS*ROWS-1, one per cycle.
- Outputs are registered. `v_wea` is low in all states except PUT, SCR_WR, CLR_ROW and CLR_ALL.
- `in_data` is sampled only at acceptance. A source holding `in_valid` while `in_ready`=0 is stalled; no bytes are lost or duplicated.

## Timing
- Reset values:
  - `in_ready`=0, `busy`=1, `v_wea`=0, `v_ada`=0, `v_dina`=0x20, `cur_col`=0, `cur_row`=0.
  - State is CLR_ALL.
- After `nRST` deasserts:
  - CLR_ALL runs COLS*ROWS cycles (1020 at the defaults).
  - The cycle after the last write, state is IDLE and `in_ready`=1.
- Printable byte accepted at cycle N:
  - N+1: `v_wea`=1 with the old `cur_addr`; cursor registers update; `in_ready`=0.
  - N+2: `in_ready`=1, unless a scroll or row clear was triggered.
- CR, LF without scroll, ignored codes: one busy cycle, `in_ready` high again at N+2. BS: same, with its write at N+1.
- Scroll: 2*(ROWS-1)*COLS + COLS cycles (1980 at the defaults) after the triggering write, then IDLE.
- `in_ready` is only ever high in IDLE.
- Reset mid-operation: an asynchronous abort.
  - All outputs immediately go to their reset values.
  - Any partial scroll is abandoned; CLR_ALL restarts after release.

## Configuration
- `CONSOLE_SCROLL_EN` defined:
  - Newline on the last row performs the scroll above; the cursor stays on row ROWS-1.
  - SCR_RD and SCR_WR exist; `v_douta` is used.
- `CONSOLE_SCROLL_EN` undefined:
  - Newline on the last row sets `cur_row`=0 and runs CLR_ROW on row 0 (COLS cycles).
  - SCR_RD and SCR_WR are not compiled; `v_douta` is unused.

## Structure
- Package `console_pkg` holds:
  - state enum `console_state_t`;
  - control-code constants `CH_BS`, `CH_LF`, `CH_FF`, `CH_CR`, `CH_SPACE`;
  - defaults for COLS and ROWS.
- No sub-module.
  - The address/cursor counters and the FSM form one module, about 200 lines of RTL.

## Test plan
- Reset release: exactly 1020 writes of 0x20 to addresses 0..1019, then `in_ready`=1, cursor (0,0).
- Send 'A' (0x41): one write of 0x41 at address 0; cursor (1,0); `in_ready` back high 2 cycles after acceptance.
- Send 60×'x' then 'y': 'y' is written at address 60; cursor (1,1).
- With `CONSOLE_SCROLL_EN`, preload row 1 with 'B' and set the cursor to row 16, then send LF:
  - address 0..59 reads 'B';
  - addresses 960..1019 hold 0x20;
  - busy for 1980 cycles.
  - Without the macro: cursor (0,0) and row 0 is cleared in 60 cycles.
- BS at col 0 is a no-op. After "AB", BS writes 0x20 at address 1 and gives cursor (1,0). FF clears all cells and homes the cursor.
- Hold `in_valid` with 'Z' during a scroll; assert `nRST`=0 mid-scroll.
  - No write occurs while `in_ready`=0.
  - Reset gives `v_wea`=0 immediately, and CLR_ALL restarts at address 0 after release.
